axi_rdata_router: RTL
=====================

Name: axi_rdata_router

Overview:
- Consumes the buffered AXI read-data beat stream (one-hot master tag, ID, data, resp, last) produced by the shared read-data latch FIFO.
- Steers each beat to the R channel of the AXI master that issued the read.
- Provides a one-entry registered slice per master so a stalled master never blocks beats for the other masters.
- Detects and drops beats with an illegal master tag, counting the drops.

Parameters:
masters, 4, number of AXI master R ports; width of the one-hot MASTER tag
id_bits, 2, AXI ID width
data_width, 512, R data width in bits

Ports:
CLK  in  1  clock; all logic rising-edge
RESET  in  1  asynchronous, active-high reset
MASTER  in  masters  one-hot destination master tag
ID  in  id_bits  beat ID
DATA  in  data_width  beat data
RESP  in  2  beat response
LAST  in  1  last beat of burst
VALID  in  1  upstream beat valid
READY  out  1  beat accepted when VALID && READY
M_RID  out  masters*id_bits  per-master ID; slice k = [k*id_bits +: id_bits]
M_RDATA  out  masters*data_width  per-master data, sliced as for M_RID
M_RRESP  out  masters*2  per-master response
M_RLAST  out  masters  per-master last
M_RVALID  out  masters  per-master valid
M_RREADY  in  masters  per-master ready
ERR_CLR  in  1  synchronous clear of ERROR and DROP_COUNT
ERROR  out  1  sticky: an illegal tag was seen
DROP_COUNT  out  16  saturating count of dropped beats

Behaviour:
- Reset (async assert, released synchronously to CLK):
  - All M_RVALID=0, M_RID/M_RDATA/M_RRESP/M_RLAST=0.
  - ERROR=0, DROP_COUNT=0.
  - READY follows its combinational definition. With all slots empty at reset, READY=1 for a legal tag.
- Per-master slot k is either EMPTY (M_RVALID[k]=0) or FULL (M_RVALID[k]=1).
  - EMPTY->FULL when a beat tagged k is accepted.
  - FULL->EMPTY when M_RREADY[k]=1 and no new beat for k is accepted that cycle.
  - FULL stays FULL with new contents when M_RREADY[k]=1 and a beat for k is accepted the same cycle (back-to-back, full throughput).
  - FULL stays FULL with contents held when M_RREADY[k]=0.
- Legal tag means exactly one bit of MASTER is set. For a legal tag k:
  - READY = !M_RVALID[k] || M_RREADY[k].
  - READY is combinational from MASTER, VALID-independent, M_RVALID and M_RREADY.
  - READY has no dependency on VALID, so there is no combinational loop with the upstream FIFO.
- Latency: a beat accepted in cycle n appears on M_R*[k] with M_RVALID[k]=1 in cycle n+1.
- Slot payload is loaded only on acceptance.
  - Payload is stable while M_RVALID[k]=1 && M_RREADY[k]=0 (AXI rule).
  - M_RVALID[k] never drops without a handshake.
- Illegal tag (zero bits or more than one bit set in MASTER):
  - READY=1 and the beat is consumed when VALID.
  - No slot changes.
  - ERROR is set the next cycle.
  - DROP_COUNT increments by 1 and saturates at 16'hFFFF (no wrap).
- ERR_CLR has priority over a same-cycle drop: result is ERROR=0, DROP_COUNT=0.
- Ordering:
  - Beats for the same master leave in acceptance order.
  - Beats for different masters are independent; interleaving between masters is permitted.
  - No reordering inside a master, since a slot holds one beat.
- LAST and ID are passed through unchanged. No burst-length checking.
- RESP is passed through unchanged.
- A reset asserted mid-burst discards all slot contents immediately (M_RVALID=0). Beats in flight are lost; upstream is reset by the same signal.

Test Plan:
- Reset, then VALID=1, MASTER=4'b0010, ID=2'd1, DATA=512'hA5, RESP=0, LAST=1, M_RREADY=4'hF -> READY=1. Next cycle M_RVALID=4'b0010, M_RID slice1=1, M_RDATA slice1=hA5, M_RLAST[1]=1. Cycle after, M_RVALID=0.
- Burst of 8 beats to master 0, DATA=0..7, M_RREADY[0]=1 throughout -> 8 consecutive handshakes, no bubbles, M_RDATA slice0 = 0..7 in order, LAST only on beat 7.
- Master 2 slot full with M_RREADY[2]=0, next beat tagged 2 -> READY=0 and the held payload stays unchanged for 5 cycles. A beat tagged 3 presented instead is accepted (READY=1) and delivered the next cycle.
- MASTER=4'b0000 then 4'b0110 with VALID=1 -> both consumed, no M_RVALID asserted, ERROR=1, DROP_COUNT=2. Pulse ERR_CLR -> ERROR=0, DROP_COUNT=0.
- Force DROP_COUNT to 16'hFFFE via 65534 illegal beats, then 3 more -> DROP_COUNT holds 16'hFFFF.
- Assert RESET while slots 0 and 1 are full -> M_RVALID=0 asynchronously (same cycle, before the clock edge). After release the first legal beat is delivered with 1-cycle latency.

Source files
------------

// File: rtl/axi_rdata_router_if.sv
// Bundles the upstream beat stream, the per-master R channels and the drop
// status of the read-data router. The DUT side uses the slave modport.
interface axi_rdata_router_if #(
  parameter int masters    = 4,
  parameter int id_bits    = 2,
  parameter int data_width = 512
);
  logic [masters-1:0]            MASTER;
  logic [id_bits-1:0]            ID;
  logic [data_width-1:0]         DATA;
  logic [1:0]                    RESP;
  logic                          LAST;
  logic                          VALID;
  logic                          READY;
  logic [masters*id_bits-1:0]    M_RID;
  logic [masters*data_width-1:0] M_RDATA;
  logic [masters*2-1:0]          M_RRESP;
  logic [masters-1:0]            M_RLAST;
  logic [masters-1:0]            M_RVALID;
  logic [masters-1:0]            M_RREADY;
  logic                          ERR_CLR;
  logic                          ERROR;
  logic [15:0]                   DROP_COUNT;

  modport slave (
    input  MASTER, ID, DATA, RESP, LAST, VALID, M_RREADY, ERR_CLR,
    output READY, M_RID, M_RDATA, M_RRESP, M_RLAST, M_RVALID, ERROR, DROP_COUNT
  );

  modport master (
    output MASTER, ID, DATA, RESP, LAST, VALID, M_RREADY, ERR_CLR,
    input  READY, M_RID, M_RDATA, M_RRESP, M_RLAST, M_RVALID, ERROR, DROP_COUNT
  );
endinterface

// File: rtl/axi_rdata_router.sv
// Steers buffered AXI read-data beats to the R channel of the tagged master
// through a one-entry slice per master; beats with a non-one-hot tag are
// dropped and counted.
//
// Per-master slot states:
//   state      | meaning
//   SLOT_EMPTY | no beat held, M_RVALID[k]=0
//   SLOT_FULL  | one beat held and presented, M_RVALID[k]=1
module axi_rdata_router #(
  parameter int masters    = 4,
  parameter int id_bits    = 2,
  parameter int data_width = 512
) (
  input logic CLK,
  input logic RESET,
  axi_rdata_router_if.slave bus
);

  localparam logic SLOT_EMPTY = 1'b0;
  localparam logic SLOT_FULL  = 1'b1;

  logic                                  legal;
  logic                                  ready;
  logic                                  accept;
  logic                                  drop;
  logic [masters-1:0]                    load;
  logic [masters-1:0]                    slot_q;
  logic [masters-1:0][id_bits-1:0]       rid_q;
  logic [masters-1:0][data_width-1:0]    rdata_q;
  logic [masters-1:0][1:0]               rresp_q;
  logic [masters-1:0]                    rlast_q;
  logic                                  error_q;
  logic [15:0]                           drop_q;

  // A tag is legal when exactly one bit is set. READY never looks at VALID,
  // so the upstream FIFO can derive its pop from VALID && READY without a loop.
  assign legal  = (bus.MASTER != '0) && ((bus.MASTER & (bus.MASTER - masters'(1))) == '0);
  assign ready  = legal ? |(bus.MASTER & (~slot_q | bus.M_RREADY)) : 1'b1;
  assign accept = bus.VALID & ready;
  assign drop   = bus.VALID & ~legal;
  assign load   = bus.MASTER & {masters{accept & legal}};

  assign bus.READY      = ready;
  assign bus.M_RVALID   = slot_q;
  assign bus.M_RID      = rid_q;
  assign bus.M_RDATA    = rdata_q;
  assign bus.M_RRESP    = rresp_q;
  assign bus.M_RLAST    = rlast_q;
  assign bus.ERROR      = error_q;
  assign bus.DROP_COUNT = drop_q;

  // Per-master slice: load on acceptance (also when draining the same cycle),
  // otherwise empty on handshake; payload held while stalled.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      slot_q  <= '0;
      rid_q   <= '0;
      rdata_q <= '0;
      rresp_q <= '0;
      rlast_q <= '0;
    end else begin
      for (int k = 0; k < masters; k++) begin
        if (load[k]) begin
          slot_q[k]  <= SLOT_FULL;
          rid_q[k]   <= bus.ID;
          rdata_q[k] <= bus.DATA;
          rresp_q[k] <= bus.RESP;
          rlast_q[k] <= bus.LAST;
        end else if (bus.M_RREADY[k]) begin
          slot_q[k]  <= SLOT_EMPTY;
        end
      end
    end
  end

  // Sticky error flag and saturating drop counter; a clear wins over a drop.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      error_q <= 1'b0;
      drop_q  <= '0;
    end else if (bus.ERR_CLR) begin
      error_q <= 1'b0;
      drop_q  <= '0;
    end else if (drop) begin
      error_q <= 1'b1;
      if (drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
    end
  end

endmodule
